// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared widths, fetch state and fetch buffer entry type for the instruction fetch unit
package ifu_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// rtl/ifu_fetch_fifo.sv - fetch buffer between the pc sequencer and decode
// Pointers carry one extra wrap bit so full and empty are distinguishable at equal indices.
module ifu_fetch_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // A pop frees the head slot in the same edge, so a full buffer can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - fetch sequencer: pc register, run/halt/fault FSM, fetch counter, buffer to decode
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter int unsigned     MEM_BYTES  = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [XLEN-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        fetch_count
);

    localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES) - XLEN'(4);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic            pc_in_range;
    logic            redirect_ok;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    assign imem_pc     = pc;
    assign pc_in_range = (pc <= LAST_PC);
    assign redirect_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);

    // A redirect cycle hides the buffer so decode never accepts a soon-to-be-flushed entry.
    assign out_valid = !fifo_empty && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = !redirect_valid && (state == ST_RUN) && pc_in_range && (!fifo_full || pop);

    assign push_data.pc    = pc;
    assign push_data.instr = imem_instr;
    assign out_instr       = head.instr;
    assign out_pc          = head.pc;

    ifu_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            state       <= ST_RUN;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            if (redirect_ok) begin
                pc     <= redirect_pc;
                state  <= ST_RUN;
                halted <= 1'b0;
                fault  <= 1'b0;
            end else begin
                state  <= ST_FAULT;
                halted <= 1'b1;
                fault  <= 1'b1;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (!pc_in_range) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else if (push) begin
                        pc          <= pc + XLEN'(4);
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - directed vector bench for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int pass_cnt;
    int total_cnt;

    logic [31:0] imem [8];

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        e_valid;
        logic [63:0] e_pc;
        logic        e_halted;
        logic        e_fault;
        logic [63:0] e_imem_pc;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs [29];

    ifu_fetch_ctrl #(
        .MEM_BYTES  (32),
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = (imem_pc < 64'd32) ? imem[imem_pc[4:2]] : 32'h0;

    function automatic logic [31:0] mem_at(input logic [63:0] a);
        return (a < 64'd32) ? imem[a[4:2]] : 32'h0;
    endfunction

    function automatic vec_t v(input logic rdy, input logic rv, input logic [63:0] rpc,
                               input logic ev, input logic [63:0] epc, input logic eh,
                               input logic ef, input logic [63:0] eim, input logic [31:0] ec);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rpc = rpc;
        r.e_valid = ev; r.e_pc = epc; r.e_halted = eh; r.e_fault = ef;
        r.e_imem_pc = eim; r.e_count = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        for (int i = 0; i < 8; i++) imem[i] = 32'h0;
        imem[0] = 32'h00940333;
        imem[1] = 32'h413903b3;
        imem[2] = 32'h035a02b3;
        imem[7] = 32'h00f768b3;

        //            rdy rv rpc    ev pc  h  f  imem cnt
        vecs[0]  = v(1, 0, 0,     1, 0,  0, 0, 4,  1);
        vecs[1]  = v(1, 0, 0,     1, 4,  0, 0, 8,  2);
        vecs[2]  = v(1, 0, 0,     1, 8,  0, 0, 12, 3);
        vecs[3]  = v(1, 0, 0,     1, 12, 0, 0, 16, 4);
        vecs[4]  = v(1, 0, 0,     1, 16, 0, 0, 20, 5);
        vecs[5]  = v(1, 0, 0,     1, 20, 0, 0, 24, 6);
        vecs[6]  = v(1, 0, 0,     1, 24, 0, 0, 28, 7);
        vecs[7]  = v(1, 0, 0,     1, 28, 0, 0, 32, 8);
        vecs[8]  = v(1, 0, 0,     0, 0,  1, 0, 32, 8);
        vecs[9]  = v(1, 1, 6,     0, 0,  1, 0, 32, 8);
        vecs[10] = v(1, 0, 0,     0, 0,  1, 1, 32, 8);
        vecs[11] = v(1, 1, 40,    0, 0,  1, 1, 32, 8);
        vecs[12] = v(1, 0, 0,     0, 0,  1, 1, 32, 8);
        vecs[13] = v(1, 1, 0,     0, 0,  1, 1, 32, 8);
        vecs[14] = v(0, 0, 0,     0, 0,  0, 0, 0,  8);
        vecs[15] = v(0, 0, 0,     1, 0,  0, 0, 4,  9);
        vecs[16] = v(0, 0, 0,     1, 0,  0, 0, 8,  10);
        vecs[17] = v(0, 0, 0,     1, 0,  0, 0, 8,  10);
        vecs[18] = v(1, 0, 0,     1, 0,  0, 0, 8,  10);
        vecs[19] = v(1, 1, 28,    0, 0,  0, 0, 12, 11);
        vecs[20] = v(1, 0, 0,     0, 0,  0, 0, 28, 11);
        vecs[21] = v(1, 0, 0,     1, 28, 0, 0, 32, 12);
        vecs[22] = v(1, 0, 0,     0, 0,  1, 0, 32, 12);
        vecs[23] = v(1, 1, 0,     0, 0,  1, 0, 32, 12);
        vecs[24] = v(0, 0, 0,     0, 0,  0, 0, 0,  12);
        vecs[25] = v(0, 0, 0,     1, 0,  0, 0, 4,  13);
        vecs[26] = v(1, 1, 6,     0, 0,  0, 0, 8,  14);
        vecs[27] = v(1, 0, 0,     0, 0,  1, 1, 8,  14);
        vecs[28] = v(1, 0, 0,     0, 0,  1, 1, 8,  14);

        reset          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        step();
        step();
        chk("reset out_valid", {63'h0, out_valid}, 64'h0);
        chk("reset halted", {63'h0, halted}, 64'h0);
        chk("reset fault", {63'h0, fault}, 64'h0);
        chk("reset imem_pc", imem_pc, 64'h0);
        chk("reset out_instr", {32'h0, out_instr}, 64'h0);
        chk("reset out_pc", out_pc, 64'h0);
        chk("reset fetch_count", {32'h0, fetch_count}, 64'h0);
        reset     = 1'b1;
        out_ready = 1'b1;

        for (int i = 0; i < 29; i++) begin
            @(posedge clk);
            #1;
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            #1;
            chk($sformatf("row%0d out_valid", i), {63'h0, out_valid}, {63'h0, vecs[i].e_valid});
            chk($sformatf("row%0d halted", i), {63'h0, halted}, {63'h0, vecs[i].e_halted});
            chk($sformatf("row%0d fault", i), {63'h0, fault}, {63'h0, vecs[i].e_fault});
            chk($sformatf("row%0d imem_pc", i), imem_pc, vecs[i].e_imem_pc);
            chk($sformatf("row%0d fetch_count", i), {32'h0, fetch_count}, {32'h0, vecs[i].e_count});
            if (vecs[i].e_valid) begin
                chk($sformatf("row%0d out_pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("row%0d out_instr", i), {32'h0, out_instr}, {32'h0, mem_at(vecs[i].e_pc)});
            end
        end
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;

        // Back-pressure straight out of reset, then resume in order.
        reset     = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("bp imem_pc", imem_pc, 64'd8);
        chk("bp fetch_count", {32'h0, fetch_count}, 64'd2);
        chk("bp out_valid", {63'h0, out_valid}, 64'h1);
        chk("bp head pc", out_pc, 64'd0);
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk($sformatf("resume%0d out_valid", j), {63'h0, out_valid}, 64'h1);
            chk($sformatf("resume%0d out_pc", j), out_pc, 64'(4 * j));
            chk($sformatf("resume%0d out_instr", j), {32'h0, out_instr}, {32'h0, mem_at(64'(4 * j))});
            chk($sformatf("resume%0d fetch_count", j), {32'h0, fetch_count}, 64'(2 + j));
            step();
        end

        // Stall with the buffer full at the halt point, then reset asynchronously.
        out_ready = 1'b0;
        step();
        chk("full halted", {63'h0, halted}, 64'h1);
        chk("full head pc", out_pc, 64'd24);
        chk("full fetch_count", {32'h0, fetch_count}, 64'd8);
        #2;
        reset = 1'b0;
        #1;
        chk("async out_valid", {63'h0, out_valid}, 64'h0);
        chk("async imem_pc", imem_pc, 64'h0);
        chk("async fetch_count", {32'h0, fetch_count}, 64'h0);
        chk("async halted", {63'h0, halted}, 64'h0);
        chk("async out_instr", {32'h0, out_instr}, 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Fetch sequencer for the RV64 instruction fetch unit. It owns the program counter, drives the instruction memory's combinational read port, and buffers fetched instructions in a small FIFO toward decode through a valid/ready handshake. It handles redirects from branch/jump resolution, stalls on decode back-pressure, and halts cleanly when the PC leaves the populated memory range.

## Interface
- MEM_BYTES, 32, size of instruction memory in bytes; a multiple of 4.
- RESET_PC, 64'h0, PC loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; a power of two, at least 2.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- imem_pc  out  64  address to instruction memory `PC` input.
- imem_instr  in  32  instruction returned combinationally for `imem_pc`.
- redirect_valid  in  1  redirect request this cycle.
- redirect_pc  in  64  redirect target.
- out_valid  out  1  buffered instruction available.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  32  instruction at FIFO head.
- out_pc  out  64  PC of `out_instr`.
- halted  out  1  fetch stopped at end of memory.
- fault  out  1  last redirect target was misaligned or out of range.
- fetch_count  out  32  instructions written into the FIFO since reset; wraps.

## Operation
- States:
  - RUN: fetching.
  - HALT: PC reached the end of memory.
  - FAULT: a bad redirect was received.
- Reset:
  - pc = RESET_PC; FIFO empty; state RUN; fetch_count = 0.
  - Outputs: out_valid = 0, halted = 0, fault = 0, imem_pc = RESET_PC, out_instr = 0, out_pc = 0.
- `imem_pc` is always the current pc register.
- RUN fetch:
  - Condition: no redirect, pc <= MEM_BYTES-4, and the FIFO is not full or a pop happens this cycle.
  - Action: push {pc, imem_instr}; pc += 4; fetch_count += 1.
  - If pc > MEM_BYTES-4 with no redirect, nothing is pushed and the state goes to HALT. The pc holds.
- Pop happens when out_valid && out_ready. A push and a pop in the same cycle on a full FIFO are both legal, so throughput is 1 instruction/cycle.
- `out_valid` is FIFO non-empty AND NOT redirect_valid. No handshake completes in a redirect cycle.
- Redirect has the highest priority and applies in any state. At the clock edge:
  - The FIFO is flushed and nothing is pushed that cycle.
  - If redirect_pc[1:0] == 0 and redirect_pc <= MEM_BYTES-4: pc = redirect_pc, state RUN, fault cleared.
  - Otherwise: pc is unchanged, state FAULT, fault = 1.
- HALT and FAULT: no fetching; the FIFO still drains to decode.
  - halted = 1 in HALT and in FAULT.
  - fault = 1 in FAULT only.
  - Leaving either state requires a valid redirect or reset.
- Width rules:
  - pc arithmetic is 64-bit unsigned.
  - Range compares are unsigned against MEM_BYTES-4, so no wrap is possible within range.

## Timing
- The fetch path is zero-latency: `imem_instr` is sampled in the same cycle `imem_pc` is driven.
- Pipeline latency is 1 cycle from fetch to output. After reset deasserts, out_valid rises in the cycle after the first rising edge.
- After a valid redirect at edge N, the target instruction appears on out_* after edge N+1.
- Back-pressure: with out_ready = 0, the FIFO fills in FIFO_DEPTH cycles, then pc holds stable.
- When reset asserts mid-operation, all state clears immediately, without waiting for a clock edge.

## Structure
- Shared package `ifu_pkg`:
  - state enum (RUN, HALT, FAULT);
  - INSTR_W = 32;
  - XLEN = 64;
  - the fifo entry struct {pc, instr}.
- Sub-module `ifu_fetch_fifo`:
  - synchronous FIFO with parameter DEPTH;
  - push/pop/flush, full/empty outputs;
  - clk/reset with the same async active-low reset.
- The top level holds the pc register, the FSM and the counter.

## Test plan
Memory contents: 0x00940333 at address 0, 0x413903b3 at 4, 0x035a02b3 at 8, 0x00f768b3 at 28.

- Reset, then out_ready = 1 held:
  - out_instr = 0x00940333 @ pc 0, then 0x413903b3 @ 4, then 0x035a02b3 @ 8, one per cycle.
  - After pc 28, halted = 1 and fetch_count = 8.
- out_ready = 0 for 5 cycles after reset:
  - FIFO holds pc 0 and pc 4; imem_pc stays 8; fetch_count = 2.
  - Raising out_ready resumes in order with no loss or duplicate.
- redirect_pc = 28 while the FIFO holds pc 4 and pc 8:
  - No handshake occurs in the redirect cycle.
  - The next output is 0x00f768b3 @ pc 28, then halted = 1.
- redirect_pc = 6 (misaligned), then redirect_pc = 40 (out of range):
  - fault = 1 and halted = 1 each time; the FIFO drains and no new fetch occurs.
  - redirect_pc = 0 then clears fault and resumes fetching at 0x00940333.
- Assert reset mid-stream while the FIFO is full:
  - out_valid = 0, imem_pc = 0 and fetch_count = 0 immediately, before any clock edge.
